// File: rtl/pipeline_pkg.sv
// Shared constants for the F = ((A+B)+(C-D))*D arithmetic pipeline and its result buffer.
package pipeline_pkg;

    localparam int PIPE_LAT = 3;
    localparam int PIPE_N   = 10;

    // Width of an occupancy counter that must be able to hold the value `depth` itself.
    function automatic int clog2p1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_result_buffer_if.sv
// Producer-side credit handshake and consumer-side ready/valid bus of the result buffer.
interface pipeline_result_buffer_if
    import pipeline_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int DEPTH = 4
);
    localparam int CW = clog2p1(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  f;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;
    logic          overflow;

    modport slave (
        input  in_valid, f, out_ready,
        output in_ready, out_valid, out_data, count, overflow
    );

    modport master (
        output in_valid, f, out_ready,
        input  in_ready, out_valid, out_data, count, overflow
    );

endinterface

// File: rtl/pipeline_result_buffer_result_fifo.sv
// Small circular FIFO holding pipeline results; a write into a full FIFO is accepted only alongside a pop.
module result_fifo
    import pipeline_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr,
    input  logic [N-1:0]                wdata,
    input  logic                        rd,
    output logic [N-1:0]                rdata,
    output logic [clog2p1(DEPTH)-1:0]   count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2p1(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_wrEn;
    logic          w_rdEn;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_rdEn = rd & ~empty;
    assign w_wrEn = wr & (~full | w_rdEn);
    assign rdata  = r_mem[r_rdPtr];
    assign count  = r_count;

    // Storage is deliberately left out of reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdEn) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wrEn, w_rdEn})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_result_buffer.sv
// Tags valid upstream cycles through a latency-matched delay line, buffers their F results and issues credit.
module pipeline_result_buffer
    import pipeline_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    pipeline_result_buffer_if.slave   bus
);
    localparam int CW = clog2p1(DEPTH);

    logic [LAT-1:0] r_vld;
    logic           r_overflow;
    logic           w_wr;
    logic           w_rd;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [N-1:0]   w_rdata;
    int             w_inFlight;

    assign w_wr = r_vld[LAT-1];
    assign w_rd = ~w_empty & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= bus.in_valid;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_comb begin
        w_inFlight = 0;
        for (int i = 0; i < LAT; i++) begin
            if (r_vld[i]) begin
                w_inFlight = w_inFlight + 1;
            end
        end
    end

    // Credit ignores a same-cycle pop, so it can only under-grant, never over-grant.
    assign bus.in_ready = ((int'(w_count) + w_inFlight) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_wr & w_full & ~w_rd) begin
            r_overflow <= 1'b1;
        end
    end

    result_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (w_wr),
        .wdata (bus.f),
        .rd    (w_rd),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_rdata;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_pipeline_result_buffer.sv
// Directed bench: models the 3-stage F pipeline upstream and checks buffering, credit and overflow behaviour.
module tb_pipeline_result_buffer;

    localparam int N     = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    logic [N-1:0] opA, opB, opC, opD;
    logic [N-1:0] p1Sum, p1Diff, p1D, p2Sum, p2D;

    pipeline_result_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    pipeline_result_buffer #(
        .N     (N),
        .LAT   (3),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    // Reference upstream pipeline: operands sampled at E_t, F registered at E_t+2, no reset.
    always @(posedge clk) begin
        p1Sum  <= opA + opB;
        p1Diff <= opC - opD;
        p1D    <= opD;
        p2Sum  <= p1Sum + p1Diff;
        p2D    <= p1D;
        bus.f  <= p2Sum * p2D;
    end

    task automatic applyStimulus(input logic v, input int a, input int b, input int c, input int d);
        bus.in_valid = v;
        opA = N'(a);
        opB = N'(b);
        opC = N'(c);
        opD = N'(d);
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, base + i, 0, 1, 1);
        end
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        nCompared++; if (bus.count !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset.count got %0d want 0", bus.count); end
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset.out_valid got %b want 0", bus.out_valid); end
        nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset.overflow got %b want 0", bus.overflow); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset.in_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            nCompared++;
            if (bus.out_valid !== (k == 4)) begin
                nMismatched++; $display("[TB] FAIL single.out_valid cycle %0d got %b want %b", k, bus.out_valid, (k == 4));
            end
            if (k == 4) begin
                nCompared++;
                if (bus.out_data !== 10'd30) begin nMismatched++; $display("[TB] FAIL single.out_data got %0d want 30", bus.out_data); end
            end
            if (k == 0) applyStimulus(1'b1, 5, 3, 9, 2);
            else        applyStimulus(1'b0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_back_to_back;
        logic         vPat [4];
        logic [N-1:0] expData [3];
        logic         expV;
        int           idx;
        vPat    = '{1'b1, 1'b1, 1'b0, 1'b1};
        expData = '{10'd12, 10'd22, 10'd36};
        idx     = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            expV = (k == 4) || (k == 5) || (k == 7);
            nCompared++;
            if (bus.out_valid !== expV) begin
                nMismatched++; $display("[TB] FAIL b2b.out_valid cycle %0d got %b want %b", k, bus.out_valid, expV);
            end
            if (expV && idx < 3) begin
                nCompared++;
                if (bus.out_data !== expData[idx]) begin
                    nMismatched++; $display("[TB] FAIL b2b.out_data beat %0d got %0d want %0d", idx, bus.out_data, expData[idx]);
                end
                idx++;
            end
            if (k < 4) applyStimulus(vPat[k], 1, 2, 10, k + 1);
            else       applyStimulus(1'b0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_credit;
        logic [N-1:0] expData [4];
        int           accepted;
        expData  = '{10'd20, 10'd42, 10'd66, 10'd92};
        accepted = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nCompared++;
            if (bus.in_ready !== (accepted < 4)) begin
                nMismatched++; $display("[TB] FAIL credit.in_ready cycle %0d got %b want %b", k, bus.in_ready, (accepted < 4));
            end
            if (bus.in_ready && accepted < 4) begin
                applyStimulus(1'b1, accepted, 1, 20 + accepted, accepted + 1);
                accepted++;
            end else begin
                applyStimulus(1'b0, 0, 0, 0, 0);
            end
        end
        @(negedge clk);
        nCompared++; if (bus.count !== 3'd4) begin nMismatched++; $display("[TB] FAIL credit.count got %0d want 4", bus.count); end
        nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL credit.overflow got %b want 0", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nCompared++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== expData[j]) begin
                nMismatched++; $display("[TB] FAIL credit.drain beat %0d got v=%b d=%0d want v=1 d=%0d", j, bus.out_valid, bus.out_data, expData[j]);
            end
            @(negedge clk);
        end
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL credit.empty got %b want 0", bus.out_valid); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL credit.reassert got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full_rdwr;
        logic [N-1:0] expData [4];
        expData = '{10'd101, 10'd102, 10'd103, 10'd200};
        bus.out_ready = 1'b0;
        fill(100, 4);
        nCompared++; if (bus.count !== 3'd4) begin nMismatched++; $display("[TB] FAIL rdwr.fill count got %0d want 4", bus.count); end
        applyStimulus(1'b1, 200, 0, 1, 1);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        nCompared++; if (bus.count !== 3'd4) begin nMismatched++; $display("[TB] FAIL rdwr.count got %0d want 4", bus.count); end
        nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL rdwr.overflow got %b want 0", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nCompared++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== expData[j]) begin
                nMismatched++; $display("[TB] FAIL rdwr.drain beat %0d got v=%b d=%0d want v=1 d=%0d", j, bus.out_valid, bus.out_data, expData[j]);
            end
            @(negedge clk);
        end
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rdwr.empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow;
        bus.out_ready = 1'b0;
        fill(300, 4);
        applyStimulus(1'b1, 500, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 0, 0, 0, 0);
            if (k == 3) begin
                nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf.early got %b want 0", bus.overflow); end
            end
        end
        nCompared++; if (bus.overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf.flag got %b want 1", bus.overflow); end
        nCompared++; if (bus.count !== 3'd4) begin nMismatched++; $display("[TB] FAIL ovf.count got %0d want 4", bus.count); end
        nCompared++; if (bus.out_data !== 10'd300) begin nMismatched++; $display("[TB] FAIL ovf.head got %0d want 300", bus.out_data); end
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nCompared++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== N'(300 + j)) begin
                nMismatched++; $display("[TB] FAIL ovf.drain beat %0d got v=%b d=%0d want v=1 d=%0d", j, bus.out_valid, bus.out_data, 300 + j);
            end
            @(negedge clk);
        end
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf.empty got %b want 0", bus.out_valid); end
        nCompared++; if (bus.overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf.sticky got %b want 1", bus.overflow); end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        fill(40, 2);
        nCompared++; if (bus.count !== 3'd2) begin nMismatched++; $display("[TB] FAIL rstmid.pre count got %0d want 2", bus.count); end
        applyStimulus(1'b1, 7, 7, 7, 7);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        nCompared++; if (bus.count !== 3'd0) begin nMismatched++; $display("[TB] FAIL rstmid.count got %0d want 0", bus.count); end
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid.out_valid got %b want 0", bus.out_valid); end
        nCompared++; if (bus.overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid.overflow got %b want 0", bus.overflow); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid.in_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid.lost got %b want 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_credit();
        test_full_rdwr();
        test_overflow();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
